alu_rs: RTL and testbench

//  Reservation station and issue scheduler for one integer ALU. Holds dispatched ALU ops until both

---
 rtl/alu_rs_pkg.sv | 25 ++
 rtl/alu_rs_age_select.sv | 47 ++++
 rtl/alu_rs.sv | 188 ++++++++++++++++++
 tb/tb_alu_rs.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_rs_pkg.sv
// Shared constants and types for the ALU reservation station.
// Station depth and tag width defaults live here next to the datapath widths.
package alu_rs_pkg;

  localparam int RV32_DATA_WIDTH = 32;
  localparam int ALU_OP_W        = 4;
  localparam int RS_ALU_ENTRIES  = 4;
  localparam int RV32_TAG_WIDTH  = 6;

  typedef logic [RV32_DATA_WIDTH-1:0] data_t;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/alu_rs_age_select.sv
// Age-matrix oldest-ready picker shared by issue stations.
// older[i][j] set means entry i was allocated before entry j.
module rs_age_select
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES = RS_ALU_ENTRIES
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ENTRIES-1:0] i_ready,
  input  logic [ENTRIES-1:0] i_alloc,
  input  logic [ENTRIES-1:0] i_free,
  output logic [ENTRIES-1:0] o_oldest,
  output logic               o_found
);

  logic [ENTRIES-1:0] older [ENTRIES];
  logic [ENTRIES-1:0] blocked;

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_rst) begin
        older[i] <= '0;
      end else begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (i_alloc[i])
            older[i][j] <= 1'b0;
          else if (i_alloc[j])
            older[i][j] <= 1'b1;
          else if (i_free[j])
            older[i][j] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    blocked = '0;
    for (int i = 0; i < ENTRIES; i++)
      for (int j = 0; j < ENTRIES; j++)
        if (i_ready[j] && older[j][i])
          blocked[i] = 1'b1;
    o_oldest = i_ready & ~blocked;
    o_found  = |i_ready;
  end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: operand capture, CDB wakeup, oldest-first
// select into a single registered issue slot.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int ENTRIES   = RS_ALU_ENTRIES,
  parameter int TAG_WIDTH = RV32_TAG_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flush,
  input  logic                 i_dp_valid,
  output logic                 o_dp_ready,
  input  logic [ALU_OP_W-1:0]  i_dp_op,
  input  data_t                i_dp_src1,
  input  logic                 i_dp_src1_rdy,
  input  logic [TAG_WIDTH-1:0] i_dp_src1_tag,
  input  data_t                i_dp_src2,
  input  logic                 i_dp_src2_rdy,
  input  logic [TAG_WIDTH-1:0] i_dp_src2_tag,
  input  logic [TAG_WIDTH-1:0] i_dp_dst_tag,
  input  logic                 i_cdb_valid,
  input  logic [TAG_WIDTH-1:0] i_cdb_tag,
  input  data_t                i_cdb_data,
  output logic                 o_iss_valid,
  input  logic                 i_iss_ready,
  output logic [ALU_OP_W-1:0]  o_iss_op,
  output data_t                o_iss_src1,
  output data_t                o_iss_src2,
  output logic [TAG_WIDTH-1:0] o_iss_dst_tag
);

  localparam int CW = $clog2(ENTRIES) + 1;
  localparam logic [CW-1:0] FULL = CW'(ENTRIES);

  typedef struct packed {
    logic                 rdy;
    logic [TAG_WIDTH-1:0] tag;
    data_t                val;
  } opnd_t;

  typedef struct packed {
    logic                 valid;
    logic [ALU_OP_W-1:0]  op;
    opnd_t                src1;
    opnd_t                src2;
    logic [TAG_WIDTH-1:0] dst;
  } ent_t;

  function automatic opnd_t wake(
    input opnd_t                o,
    input logic                 v,
    input logic [TAG_WIDTH-1:0] t,
    input data_t                d
  );
    opnd_t r;
    r = o;
    if (v && !o.rdy && o.tag == t) begin
      r.rdy = 1'b1;
      r.val = d;
    end
    return r;
  endfunction

  ent_t                 ent [ENTRIES];
  ent_t                 new_ent;
  logic [CW-1:0]        cnt;
  logic [ENTRIES-1:0]   alloc;
  logic [ENTRIES-1:0]   rdy_vec;
  logic [ENTRIES-1:0]   sel;
  logic                 hit;
  logic                 found;
  logic                 dp_fire;
  logic                 slot_load;
  logic [ALU_OP_W-1:0]  sel_op;
  data_t                sel_v1;
  data_t                sel_v2;
  logic [TAG_WIDTH-1:0] sel_dst;

  assign o_dp_ready = (cnt < FULL);
  assign dp_fire    = i_dp_valid & o_dp_ready;
  assign slot_load  = found & (~o_iss_valid | i_iss_ready);

  // a dispatching operand can be satisfied by the same-cycle broadcast
  always_comb begin
    new_ent       = '0;
    new_ent.valid = 1'b1;
    new_ent.op    = i_dp_op;
    new_ent.dst   = i_dp_dst_tag;
    new_ent.src1  = wake({i_dp_src1_rdy, i_dp_src1_tag, i_dp_src1},
                         i_cdb_valid, i_cdb_tag, i_cdb_data);
    new_ent.src2  = wake({i_dp_src2_rdy, i_dp_src2_tag, i_dp_src2},
                         i_cdb_valid, i_cdb_tag, i_cdb_data);
  end

  always_comb begin
    alloc = '0;
    hit   = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!ent[i].valid && !hit) begin
        alloc[i] = 1'b1;
        hit      = 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      rdy_vec[i] = ent[i].valid & ent[i].src1.rdy & ent[i].src2.rdy;
  end

  rs_age_select #(
    .ENTRIES (ENTRIES)
  ) u_age (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ready  (rdy_vec),
    .i_alloc  (alloc & {ENTRIES{dp_fire & ~i_flush}}),
    .i_free   (sel & {ENTRIES{slot_load}}),
    .o_oldest (sel),
    .o_found  (found)
  );

  always_comb begin
    sel_op  = '0;
    sel_v1  = '0;
    sel_v2  = '0;
    sel_dst = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (sel[i]) begin
        sel_op  = ent[i].op;
        sel_v1  = ent[i].src1.val;
        sel_v2  = ent[i].src2.val;
        sel_dst = ent[i].dst;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_rst || i_flush) begin
        ent[i].valid <= 1'b0;
      end else if (dp_fire && alloc[i]) begin
        ent[i] <= new_ent;
      end else begin
        if (slot_load && sel[i])
          ent[i].valid <= 1'b0;
        ent[i].src1 <= wake(ent[i].src1, i_cdb_valid,
                            i_cdb_tag, i_cdb_data);
        ent[i].src2 <= wake(ent[i].src2, i_cdb_valid,
                            i_cdb_tag, i_cdb_data);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_iss_valid   <= 1'b0;
      o_iss_op      <= '0;
      o_iss_src1    <= '0;
      o_iss_src2    <= '0;
      o_iss_dst_tag <= '0;
    end else if (slot_load) begin
      o_iss_valid   <= 1'b1;
      o_iss_op      <= sel_op;
      o_iss_src1    <= sel_v1;
      o_iss_src2    <= sel_v2;
      o_iss_dst_tag <= sel_dst;
    end else if (i_iss_ready) begin
      o_iss_valid   <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush)
      cnt <= '0;
    else
      cnt <= cnt + CW'(dp_fire) - CW'(slot_load);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (cnt <= FULL);
      assert (!(slot_load && cnt == '0));
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed and random checks of alu_rs against a queue-ordered
// reference model of station contents and the issue slot.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, dpv, dp_rdy;
  logic [3:0]  dop;
  logic [31:0] ds1, ds2, cdata;
  logic        dr1, dr2, cdbv;
  logic [5:0]  dt1, dt2, ddst, ctag;
  logic        iss_v, iss_rdy;
  logic [3:0]  iss_op;
  logic [31:0] iss_s1, iss_s2;
  logic [5:0]  iss_dst;

  always #5 clk = ~clk;

  alu_rs #(.ENTRIES(4), .TAG_WIDTH(6)) dut (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_dp_valid(dpv), .o_dp_ready(dp_rdy), .i_dp_op(dop),
    .i_dp_src1(ds1), .i_dp_src1_rdy(dr1), .i_dp_src1_tag(dt1),
    .i_dp_src2(ds2), .i_dp_src2_rdy(dr2), .i_dp_src2_tag(dt2),
    .i_dp_dst_tag(ddst),
    .i_cdb_valid(cdbv), .i_cdb_tag(ctag), .i_cdb_data(cdata),
    .o_iss_valid(iss_v), .i_iss_ready(iss_rdy), .o_iss_op(iss_op),
    .o_iss_src1(iss_s1), .o_iss_src2(iss_s2), .o_iss_dst_tag(iss_dst)
  );

  typedef struct {
    logic [3:0]  op;
    bit          r1;
    logic [5:0]  t1;
    logic [31:0] v1;
    bit          r2;
    logic [5:0]  t2;
    logic [31:0] v2;
    logic [5:0]  dst;
  } m_t;

  m_t          mq[$];
  logic        m_sv;
  logic [3:0]  m_op;
  logic [31:0] m_s1, m_s2;
  logic [5:0]  m_dst;
  logic [5:0]  issued[$];
  int          nassert = 0;
  int          nfail = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic setdp(input logic [3:0] op, input logic [31:0] s1,
                       input logic r1, input logic [5:0] t1,
                       input logic [31:0] s2, input logic r2,
                       input logic [5:0] t2, input logic [5:0] dst);
    dpv = 1'b1; dop = op; ds1 = s1; dr1 = r1; dt1 = t1;
    ds2 = s2; dr2 = r2; dt2 = t2; ddst = dst;
  endtask

  task automatic setcdb(input logic [5:0] t, input logic [31:0] d);
    cdbv = 1'b1; ctag = t; cdata = d;
  endtask

  task automatic idle();
    dpv = 1'b0; cdbv = 1'b0;
  endtask

  // Oldest ready = first ready element of the dispatch-ordered queue.
  task automatic tick();
    bit  fire;
    int  sel;
    m_t  e;
    if (iss_v && iss_rdy && !rst && !flush)
      issued.push_back(iss_dst);
    if (rst || flush) begin
      mq.delete();
      m_sv = 0; m_op = 0; m_s1 = 0; m_s2 = 0; m_dst = 0;
    end else begin
      fire = dpv && (mq.size() < 4);
      sel = -1;
      for (int i = 0; i < mq.size(); i++)
        if (sel < 0 && mq[i].r1 && mq[i].r2) sel = i;
      if (sel >= 0 && (!m_sv || iss_rdy)) begin
        m_sv = 1; m_op = mq[sel].op; m_s1 = mq[sel].v1;
        m_s2 = mq[sel].v2; m_dst = mq[sel].dst;
        mq.delete(sel);
      end else if (iss_rdy) begin
        m_sv = 0;
      end
      for (int i = 0; i < mq.size(); i++) begin
        if (cdbv && !mq[i].r1 && mq[i].t1 == ctag) begin
          mq[i].r1 = 1; mq[i].v1 = cdata;
        end
        if (cdbv && !mq[i].r2 && mq[i].t2 == ctag) begin
          mq[i].r2 = 1; mq[i].v2 = cdata;
        end
      end
      if (fire) begin
        e.op = dop; e.r1 = dr1; e.t1 = dt1; e.v1 = ds1;
        e.r2 = dr2; e.t2 = dt2; e.v2 = ds2; e.dst = ddst;
        if (cdbv && !e.r1 && e.t1 == ctag) begin e.r1 = 1; e.v1 = cdata; end
        if (cdbv && !e.r2 && e.t2 == ctag) begin e.r2 = 1; e.v2 = cdata; end
        mq.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    chk("iss_valid", iss_v, m_sv);
    chk("dp_ready", dp_rdy, mq.size() < 4);
    if (m_sv) begin
      chk("iss_op", iss_op, m_op);
      chk("iss_src1", iss_s1, m_s1);
      chk("iss_src2", iss_s2, m_s2);
      chk("iss_dst", iss_dst, m_dst);
    end
  endtask

  initial begin
    rst = 1; flush = 0; iss_rdy = 1;
    idle();
    setdp(4'd0, 0, 0, 0, 0, 0, 0, 0);
    dpv = 0;

    // reset
    tick(); tick();
    chk("rst_valid", iss_v, 0);
    chk("rst_dp_ready", dp_rdy, 1);
    chk("rst_op", iss_op, 0);
    chk("rst_src1", iss_s1, 0);
    chk("rst_src2", iss_s2, 0);
    chk("rst_dst", iss_dst, 0);
    rst = 0;
    tick();

    // all-ready dispatch: t+2 latency
    setdp(ALU_ADD, 5, 1, 0, 7, 1, 0, 3);
    tick();
    idle();
    chk("add_t1_valid", iss_v, 0);
    tick();
    chk("add_valid", iss_v, 1);
    chk("add_op", iss_op, ALU_ADD);
    chk("add_src1", iss_s1, 5);
    chk("add_src2", iss_s2, 7);
    chk("add_dst", iss_dst, 3);
    tick(); tick();

    // wakeup two cycles after dispatch
    setdp(ALU_SUB, 0, 0, 9, 1, 1, 0, 5);
    tick();
    idle();
    tick();
    setcdb(9, 20);
    tick();
    idle();
    chk("wake_c1_valid", iss_v, 0);
    tick();
    chk("wake_valid", iss_v, 1);
    chk("wake_src1", iss_s1, 20);
    chk("wake_src2", iss_s2, 1);
    tick(); tick();

    // dispatch-cycle bypass
    setdp(ALU_SUB, 0, 0, 9, 1, 1, 0, 6);
    setcdb(9, 33);
    tick();
    idle();
    tick();
    chk("byp_valid", iss_v, 1);
    chk("byp_src1", iss_s1, 33);
    chk("byp_dst", iss_dst, 6);
    tick(); tick();

    // age order: B, C, then A ahead of same-cycle-eligible D
    issued.delete();
    setdp(ALU_ADD, 0, 0, 4, 1, 1, 0, 10); tick();
    setdp(ALU_ADD, 1, 1, 0, 2, 1, 0, 11); tick();
    setdp(ALU_ADD, 3, 1, 0, 4, 1, 0, 12); tick();
    setdp(ALU_ADD, 5, 1, 0, 6, 1, 0, 13);
    setcdb(4, 50);
    tick();
    idle();
    for (int k = 0; k < 6; k++) tick();
    chk("age_count", issued.size(), 4);
    if (issued.size() == 4) begin
      chk("age_0", issued[0], 11);
      chk("age_1", issued[1], 12);
      chk("age_2", issued[2], 10);
      chk("age_3", issued[3], 13);
    end

    // full station with stalled slot
    iss_rdy = 0;
    for (int k = 0; k < 5; k++) begin
      chk("fill_dp_ready", dp_rdy, 1);
      setdp(ALU_OR, 32'(100 + k), 1, 0, 32'(200 + k), 1, 0, 6'(20 + k));
      tick();
    end
    chk("full_dp_ready", dp_rdy, 0);
    chk("full_valid", iss_v, 1);
    setdp(ALU_XOR, 9, 1, 0, 9, 1, 0, 30);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_dst", iss_dst, 20);
      chk("stall_src1", iss_s1, 100);
      chk("stall_src2", iss_s2, 200);
      chk("stall_dp_ready", dp_rdy, 0);
    end
    idle();
    issued.delete();
    iss_rdy = 1;
    for (int k = 0; k < 5; k++) tick();
    chk("drain_count", issued.size(), 5);
    for (int k = 0; k < 5 && k < issued.size(); k++)
      chk("drain_order", issued[k], 32'(20 + k));
    tick(); tick();

    // flush with three entries and a held slot
    iss_rdy = 0;
    for (int k = 0; k < 4; k++) begin
      setdp(ALU_AND, 32'(k), 1, 0, 1, 1, 0, 6'(40 + k));
      tick();
    end
    setdp(ALU_AND, 7, 1, 0, 7, 1, 0, 44);
    flush = 1;
    tick();
    flush = 0;
    idle();
    chk("flush_valid", iss_v, 0);
    chk("flush_dp_ready", dp_rdy, 1);
    chk("flush_dst", iss_dst, 0);
    iss_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush_drop", iss_v, 0);
    end

    // random traffic
    for (int k = 0; k < 500; k++) begin
      flush   = ($urandom_range(0, 39) == 0);
      dpv     = 1'($urandom_range(0, 1));
      dop     = 4'($urandom_range(0, 9));
      ds1     = $urandom;
      dr1     = 1'($urandom_range(0, 1));
      dt1     = 6'($urandom_range(0, 7));
      ds2     = $urandom;
      dr2     = 1'($urandom_range(0, 1));
      dt2     = 6'($urandom_range(0, 7));
      ddst    = 6'($urandom_range(0, 63));
      cdbv    = 1'($urandom_range(0, 1));
      ctag    = 6'($urandom_range(0, 7));
      cdata   = $urandom;
      iss_rdy = ($urandom_range(0, 3) != 0);
      tick();
    end
    flush = 0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nassert, nfail);
    $finish;
  end

endmodule
